// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// banked memory responder (slave).
//
// Handshake: a request is offered whenever exactly one of rd/wr is high with
// a word-aligned addr. It is taken in the first cycle where stall=0. While
// stall=1 the master must hold addr/rd/wr/data_in unchanged. A malformed
// request (err=1) is never taken and never stalls. Read data comes back two
// cycles after acceptance as a one-cycle data_valid strobe. Writes return no
// strobe.
interface banked_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, data_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, data_valid, stall, busy, err
  );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank, word-interleaved SRAM responder. Each bank stays occupied for
// BUSY_CYC cycles per access. Reads return with a fixed two-cycle latency,
// so back-to-back reads to different banks pipeline.
module banked_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int ROWS_LOG2 = 10,
  parameter int BUSY_CYC  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  banked_mem_responder_if.slave  bus
);

  localparam int              CNT_W    = (BUSY_CYC > 2) ? $clog2(BUSY_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYC - 1);
  localparam int              ROWS     = 1 << ROWS_LOG2;

  logic [1:0]           bank;
  logic [ROWS_LOG2-1:0] row;
  logic                 req_one;
  logic                 bank_busy;
  logic                 accept;
  logic [3:0]           busy_v;
  logic [CNT_W-1:0]     cnt [4];

  logic [DATA_W-1:0]    mem [4][ROWS];
  logic                 s1_valid;
  logic [DATA_W-1:0]    s1_data;
  logic                 dv_q;
  logic [DATA_W-1:0]    dout_q;

  // Address bits above the row field alias onto the same word.
  logic unused_hi_addr;
  assign unused_hi_addr = ^bus.addr[ADDR_W-1:3+ROWS_LOG2];

  assign bank      = bus.addr[2:1];
  assign row       = bus.addr[3+ROWS_LOG2-1:3];
  assign req_one   = bus.rd ^ bus.wr;
  assign bank_busy = busy_v[bank];
  assign accept    = req_one & ~bus.addr[0] & ~bank_busy;

  assign bus.stall      = req_one & ~bus.addr[0] & bank_busy;
  assign bus.err        = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
  assign bus.busy       = busy_v;
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;

  // A bank is occupied while its down-counter is non-zero.
  always_comb begin
    busy_v = '0;
    for (int b = 0; b < 4; b++) busy_v[b] = (cnt[b] != '0);
  end

  // Per-bank occupancy counters: reload on accept, otherwise count down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && bank == 2'(b)) cnt[b] <= CNT_LOAD;
        else if (cnt[b] != '0)       cnt[b] <= cnt[b] - 1'b1;
      end
    end
  end

  // Array write at the end of the accept cycle, plus the stage-1 read capture.
  // Contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr && !rst) mem[bank][row] <= bus.data_in;
    s1_data <= mem[bank][row];
  end

  // Read pipeline control: stage 1 tag, then registered output strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      s1_valid <= accept & bus.rd;
      dv_q     <= s1_valid;
      dout_q   <= s1_valid ? s1_data : '0;
    end
  end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder. Expected read data is pushed when
// an accepted read is driven and popped by the output monitor on data_valid.
module tb_banked_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] d0, d2, d4, d6, d8;

  banked_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  banked_mem_responder #(
    .ADDR_W(16), .DATA_W(16), .ROWS_LOG2(10), .BUSY_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns 2 time units after the edge so
  // combinational outputs have settled.
  task automatic go(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) go(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Scoreboard: compare each returned word against the oldest expectation.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {16'h0, bus.data_out}, 32'hDEAD_0000);
      end else begin
        chk("rd_data", {16'h0, bus.data_out}, {16'h0, exp_q.pop_front()});
      end
    end else if (!rst) begin
      chk("data_out_idle_zero", {16'h0, bus.data_out}, 32'h0);
    end
  end

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
    d0 = 16'($urandom_range(0, 16'hFFFF));
    d2 = 16'($urandom_range(0, 16'hFFFF));
    d4 = 16'($urandom_range(0, 16'hFFFF));
    d6 = 16'($urandom_range(0, 16'hFFFF));
    d8 = 16'($urandom_range(0, 16'hFFFF));

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_data_out", {16'h0, bus.data_out}, 32'h0);
    chk("rst_data_valid", {31'h0, bus.data_valid}, 32'h0);
    chk("rst_stall", {31'h0, bus.stall}, 32'h0);
    chk("rst_busy", {28'h0, bus.busy}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Preload: 0x08 (bank0), then banks 1..3, then 0x00 once bank0 frees.
    go(1'b0, 1'b1, 16'h0008, d8);
    go(1'b0, 1'b1, 16'h0002, d2);
    go(1'b0, 1'b1, 16'h0004, d4);
    go(1'b0, 1'b1, 16'h0006, d6);
    go(1'b0, 1'b1, 16'h0000, d0);
    chk("preload_reaccept_stall", {31'h0, bus.stall}, 32'h0);
    idle(4);

    // Test 1: write then read-after-write at T+4.
    go(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("t1_wr_stall", {31'h0, bus.stall}, 32'h0);
    idle(1);
    chk("t1_busy_t1", {28'h0, bus.busy}, 32'h1);
    idle(2);
    chk("t1_busy_t3", {28'h0, bus.busy}, 32'h1);
    go(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t1_rd_stall", {31'h0, bus.stall}, 32'h0);
    chk("t1_busy_t4", {28'h0, bus.busy}, 32'h0);
    exp_q.push_back(16'hBEEF);
    idle(1);
    chk("t1_dv_t5", {31'h0, bus.data_valid}, 32'h0);
    idle(1);
    chk("t1_dv_t6", {31'h0, bus.data_valid}, 32'h1);
    idle(2);

    // Test 2: reads to all four banks back to back.
    go(1'b1, 1'b0, 16'h0000, 16'h0000); exp_q.push_back(d0);
    chk("t2_stall0", {31'h0, bus.stall}, 32'h0);
    go(1'b1, 1'b0, 16'h0002, 16'h0000); exp_q.push_back(d2);
    chk("t2_stall1", {31'h0, bus.stall}, 32'h0);
    chk("t2_dv_t1", {31'h0, bus.data_valid}, 32'h0);
    go(1'b1, 1'b0, 16'h0004, 16'h0000); exp_q.push_back(d4);
    chk("t2_stall2", {31'h0, bus.stall}, 32'h0);
    chk("t2_dv_t2", {31'h0, bus.data_valid}, 32'h1);
    go(1'b1, 1'b0, 16'h0006, 16'h0000); exp_q.push_back(d6);
    chk("t2_stall3", {31'h0, bus.stall}, 32'h0);
    chk("t2_dv_t3", {31'h0, bus.data_valid}, 32'h1);
    chk("t2_busy_t3", {28'h0, bus.busy}, 32'h7);
    idle(1);
    chk("t2_busy_t4", {28'h0, bus.busy}, 32'hE);
    chk("t2_dv_t4", {31'h0, bus.data_valid}, 32'h1);
    idle(1);
    chk("t2_dv_t5", {31'h0, bus.data_valid}, 32'h1);
    idle(1);
    chk("t2_dv_t6", {31'h0, bus.data_valid}, 32'h0);
    idle(2);

    // Test 3: same-bank conflict, requester holds until stall drops.
    go(1'b1, 1'b0, 16'h0000, 16'h0000); exp_q.push_back(d0);
    chk("t3_stall_t0", {31'h0, bus.stall}, 32'h0);
    go(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("t3_stall_t1", {31'h0, bus.stall}, 32'h1);
    go(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("t3_stall_t2", {31'h0, bus.stall}, 32'h1);
    chk("t3_dv_t2", {31'h0, bus.data_valid}, 32'h1);
    go(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("t3_stall_t3", {31'h0, bus.stall}, 32'h1);
    go(1'b1, 1'b0, 16'h0008, 16'h0000); exp_q.push_back(d8);
    chk("t3_stall_t4", {31'h0, bus.stall}, 32'h0);
    idle(1);
    chk("t3_dv_t5", {31'h0, bus.data_valid}, 32'h0);
    idle(1);
    chk("t3_dv_t6", {31'h0, bus.data_valid}, 32'h1);
    idle(3);

    // Test 4: malformed requests are flagged, never stall, never accepted.
    go(1'b1, 1'b1, 16'h0004, 16'h5555);
    chk("t4_err_rdwr", {31'h0, bus.err}, 32'h1);
    chk("t4_stall_rdwr", {31'h0, bus.stall}, 32'h0);
    go(1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("t4_err_odd", {31'h0, bus.err}, 32'h1);
    chk("t4_stall_odd", {31'h0, bus.stall}, 32'h0);
    go(1'b0, 1'b1, 16'h0005, 16'h6666);
    chk("t4_err_odd_wr", {31'h0, bus.err}, 32'h1);
    idle(1);
    chk("t4_busy", {28'h0, bus.busy}, 32'h0);
    chk("t4_err_clear", {31'h0, bus.err}, 32'h0);
    idle(1);
    chk("t4_dv", {31'h0, bus.data_valid}, 32'h0);
    idle(2);

    // Test 5: reset mid-read cancels the return and frees the bank.
    go(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("t5_stall_t0", {31'h0, bus.stall}, 32'h0);
    go(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0002;
    #1;
    chk("t5_dv_t2", {31'h0, bus.data_valid}, 32'h0);
    chk("t5_busy_t2", {28'h0, bus.busy}, 32'h0);
    chk("t5_stall_t2", {31'h0, bus.stall}, 32'h0);
    exp_q.push_back(d2);
    idle(1);
    chk("t5_dv_t3", {31'h0, bus.data_valid}, 32'h0);
    idle(1);
    chk("t5_dv_t4", {31'h0, bus.data_valid}, 32'h1);
    idle(2);

    // Test 6: address aliasing above the row field.
    go(1'b0, 1'b1, 16'h0000, 16'h1234);
    idle(3);
    go(1'b1, 1'b0, 16'h2000, 16'h0000); exp_q.push_back(16'h1234);
    chk("t6_stall", {31'h0, bus.stall}, 32'h0);
    idle(2);
    chk("t6_dv", {31'h0, bus.data_valid}, 32'h1);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
